multdiv_unit: RTL
=================

MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 Parameters: none; the datapath width SHALL be fixed at 32 bits.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  reset; asynchronous and active-low.
REQ-004 data_operandA  input  32  multiplicand / dividend, two's complement.
REQ-005 data_operandB  input  32  multiplier / divisor, two's complement.
REQ-006 ctrl_MULT  input  1  one-cycle start pulse for a multiply.
REQ-007 ctrl_DIV  input  1  one-cycle start pulse for a divide.
REQ-008 data_result  output  32  low 32 bits of the product, or the quotient.
REQ-009 data_exception  output  1  overflow or divide-fault flag for the completed operation.
REQ-010 data_resultRDY  output  1  single-cycle completion strobe.
REQ-011 busy  output  1  high while an operation is in flight.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, MULT, DIV; the reset state SHALL be IDLE.
REQ-013 Start handling:
- In IDLE, a start pulse sampled high SHALL capture both operands, clear the 6-bit iteration counter, and set busy on the next edge.
- If ctrl_MULT and ctrl_DIV are high together, the start SHALL be treated as a multiply.
REQ-014 Start pulses received while busy=1 SHALL be ignored; captured operands SHALL NOT change.
REQ-015 The multiply SHALL be a signed 32x32 operation that retires one iteration per cycle for 32 iterations, with a 64-bit partial product.
REQ-016 The divide SHALL be a signed restoring divide on operand magnitudes, one quotient bit per cycle for 32 iterations:
- The quotient SHALL truncate toward zero.
- The quotient sign SHALL be the XOR of the operand signs.
- The remainder SHALL be discarded.
REQ-017 Latency:
- If the start is sampled at edge N, data_resultRDY SHALL be high for exactly the cycle following edge N+33.
- busy SHALL fall at that same edge.
- The FSM SHALL return to IDLE there.
REQ-018 A new start SHALL be accepted in the cycle in which data_resultRDY is high.
REQ-019 data_result and data_exception SHALL update only at completion and SHALL hold until the next completion.
REQ-020 Multiply exception: data_exception=1 iff the 64-bit product is not the sign-extension of its low 32 bits.
REQ-021 Divide by zero (data_operandB=0) SHALL give data_result=0 and data_exception=1 at the normal 33-cycle latency.
REQ-022 0x80000000 / 0xFFFFFFFF SHALL give data_result=0x80000000 and data_exception=1.
REQ-023 Every other divide SHALL give data_exception=0.

Reset
REQ-024 reset_n low SHALL immediately force all of the following, regardless of clock:
- FSM to IDLE;
- busy=0;
- data_resultRDY=0;
- data_exception=0;
- data_result=0;
- iteration counter to 0.
REQ-025 On reset mid-operation, the operation SHALL be abandoned and SHALL NOT later produce data_resultRDY.
REQ-026 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Configuration
REQ-027 With macro MULTDIV_DIV_EN defined, the DIV state and the divider datapath SHALL be compiled in and behave per REQ-016 and REQ-021 to REQ-023.
REQ-028 Without MULTDIV_DIV_EN, the divider logic SHALL be absent, and a divide start accepted in IDLE SHALL:
- raise data_resultRDY one cycle later;
- return data_result=0 and data_exception=1;
- keep busy=1 for that single cycle.

Verification
REQ-029 7 * 0xFFFFFFFD (-3) -> data_result=0xFFFFFFEB, data_exception=0; data_resultRDY high exactly 33 cycles after the start edge, for one cycle.
REQ-030 0x00010000 * 0x00010000 -> data_result=0x00000000, data_exception=1; 0x7FFFFFFF * 1 -> 0x7FFFFFFF, data_exception=0.
REQ-031 Divide cases:
- 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD, exception 0.
- 100 / 0xFFFFFFF6 (-10) -> 0xFFFFFFF6, exception 0.
- 5 / 0 -> 0, exception 1.
- 0x80000000 / 0xFFFFFFFF -> 0x80000000, exception 1.
REQ-032 ctrl_MULT pulsed again at cycle 10 of a running multiply with new operands -> ignored; the original result is returned at cycle 33.
REQ-033 reset_n pulsed low at cycle 15 of a divide -> all outputs 0 immediately; no data_resultRDY follows; a fresh multiply 3*4 afterwards returns 12 at cycle 33.
REQ-034 Build without MULTDIV_DIV_EN; pulse ctrl_DIV with 8/2 -> data_resultRDY one cycle later with data_result=0, data_exception=1; multiply is unaffected.

Source files
------------

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed 32-bit multiply/divide, one bit per cycle, result 33 edges after start.
// Define MULTDIV_DIV_EN to build the restoring divider; without it a divide returns a fault after one cycle.
module multdiv_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;
  state_t state, stateNext;
  logic [5:0] iterCnt, iterCntNext;
  logic [63:0] acc, accNext, mcand, mcandNext;
  logic [31:0] opB, opBNext, resultNext;
  logic excNext, rdyNext, busyNext, done;
`ifdef MULTDIV_DIV_EN
  logic negQuot, negQuotNext, divZero, divZeroNext, divOvf, divOvfNext;
  logic [63:0] divShift;
  logic [32:0] divDiff;
  function automatic logic [31:0] mag(input logic [31:0] x);
    return x[31] ? -x : x;
  endfunction
`endif
  assign done = iterCnt == 6'd32;
  always_comb begin
    stateNext = state;
    iterCntNext = iterCnt;
    accNext = acc;
    mcandNext = mcand;
    opBNext = opB;
    resultNext = data_result;
    excNext = data_exception;
    rdyNext = 1'b0;
    busyNext = busy;
`ifdef MULTDIV_DIV_EN
    negQuotNext = negQuot;
    divZeroNext = divZero;
    divOvfNext = divOvf;
    // acc holds {partial remainder, dividend/quotient}; shift one bit in and try to subtract
    divShift = {acc[62:0], 1'b0};
    divDiff = {1'b0, divShift[63:32]} - {1'b0, opB};
`endif
    case (state)
      IDLE: if (ctrl_MULT || ctrl_DIV) begin
        stateNext = ctrl_MULT ? MULT : DIV;
        iterCntNext = 6'd0;
        busyNext = 1'b1;
        opBNext = data_operandB;
        accNext = 64'd0;
        mcandNext = {{32{data_operandA[31]}}, data_operandA};
`ifdef MULTDIV_DIV_EN
        if (!ctrl_MULT) begin
          accNext = {32'd0, mag(data_operandA)};
          opBNext = mag(data_operandB);
          negQuotNext = data_operandA[31] ^ data_operandB[31];
          divZeroNext = data_operandB == 32'd0;
          divOvfNext = data_operandA == 32'h8000_0000 && data_operandB == 32'hFFFF_FFFF;
        end
`endif
      end
      MULT: if (done) begin
        stateNext = IDLE;
        busyNext = 1'b0;
        rdyNext = 1'b1;
        resultNext = acc[31:0];
        excNext = !(&acc[63:31] || !(|acc[63:31]));
      end else begin
        // the multiplier's sign bit carries weight -2^31, so the last partial product is subtracted
        accNext = opB[iterCnt[4:0]] ? (iterCnt == 6'd31 ? acc - mcand : acc + mcand) : acc;
        mcandNext = {mcand[62:0], 1'b0};
        iterCntNext = iterCnt + 6'd1;
      end
`ifdef MULTDIV_DIV_EN
      DIV: if (done) begin
        stateNext = IDLE;
        busyNext = 1'b0;
        rdyNext = 1'b1;
        resultNext = divZero ? 32'd0 : negQuot ? -acc[31:0] : acc[31:0];
        excNext = divZero || divOvf;
      end else begin
        accNext = divDiff[32] ? divShift : {divDiff[31:0], divShift[31:1], 1'b1};
        iterCntNext = iterCnt + 6'd1;
      end
`else
      DIV: begin
        stateNext = IDLE;
        busyNext = 1'b0;
        rdyNext = 1'b1;
        resultNext = 32'd0;
        excNext = 1'b1;
      end
`endif
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      iterCnt <= 6'd0;
      acc <= 64'd0;
      mcand <= 64'd0;
      opB <= 32'd0;
      data_result <= 32'd0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy <= 1'b0;
`ifdef MULTDIV_DIV_EN
      negQuot <= 1'b0;
      divZero <= 1'b0;
      divOvf <= 1'b0;
`endif
    end else begin
      state <= stateNext;
      iterCnt <= iterCntNext;
      acc <= accNext;
      mcand <= mcandNext;
      opB <= opBNext;
      data_result <= resultNext;
      data_exception <= excNext;
      data_resultRDY <= rdyNext;
      busy <= busyNext;
`ifdef MULTDIV_DIV_EN
      negQuot <= negQuotNext;
      divZero <= divZeroNext;
      divOvf <= divOvfNext;
`endif
    end
  end
endmodule
